// File: rtl/sha_ctrl_pkg.sv
// Shared control definitions for the bitcoin_hash nonce sequencing logic.
package sha_ctrl_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int SHA_NONCE_W = 32;
    localparam int ADDR_W      = 16;
    localparam int CNT_W       = 16;
endpackage

// File: rtl/nonce_dispatcher_rr_arbiter.sv
// Round-robin picker: grants the first requester at or after ptr, wrapping.
module rr_arbiter #(
    parameter int W  = 4,
    parameter int PW = $clog2(W)
) (
    input  logic [W-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [W-1:0]  gnt,
    output logic          valid
);
    logic [PW:0]   sum;
    logic [PW-1:0] idx;

    always_comb begin
        gnt   = '0;
        valid = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < W; k++) begin
            // One extra bit keeps ptr+k from overflowing before the wrap.
            sum = {1'b0, ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(W)) sum = sum - (PW+1)'(W);
            idx = sum[PW-1:0];
            if (!valid && req[idx]) begin
                gnt[idx] = 1'b1;
                valid    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/nonce_dispatcher.sv
// Issues nonces to idle SHA-256 cores and serialises their H0 results onto
// the single memory write port at output_addr + nonce.
module nonce_dispatcher
    import sha_ctrl_pkg::*;
#(
    parameter int NUM_CORES  = 4,
    parameter int NUM_NONCES = 16,
    parameter int NONCE_W    = SHA_NONCE_W
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           start,
    input  logic [ADDR_W-1:0]              output_addr,
    output logic                           done,
    input  logic [NUM_CORES-1:0]           core_ready,
    output logic [NUM_CORES-1:0]           core_start,
    output logic [NONCE_W-1:0]             core_nonce,
    input  logic [NUM_CORES-1:0]           res_valid,
    input  logic [NUM_CORES*NONCE_W-1:0]   res_h0,
    output logic [NUM_CORES-1:0]           res_ack,
    output logic                           mem_we,
    output logic [ADDR_W-1:0]              mem_addr,
    output logic [NONCE_W-1:0]             mem_write_data,
    output logic                           err
);
    localparam int              PW   = $clog2(NUM_CORES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_NONCES);

    state_e                           state_q, state_d;
    logic [ADDR_W-1:0]                out_base_q, out_base_d;
    logic [CNT_W-1:0]                 next_nonce_q, next_nonce_d;
    logic [CNT_W-1:0]                 written_q, written_d;
    logic [NUM_CORES-1:0]             busy_q, busy_d;
    logic [NUM_CORES-1:0][CNT_W-1:0]  tag_q, tag_d;
    logic [PW-1:0]                    disp_ptr_q, disp_ptr_d;
    logic [PW-1:0]                    col_ptr_q, col_ptr_d;
    logic [NUM_CORES-1:0]             core_start_q, core_start_d;
    logic [NUM_CORES-1:0]             res_ack_q, res_ack_d;
    logic [NONCE_W-1:0]               core_nonce_q, core_nonce_d;
    logic [NONCE_W-1:0]               mem_wdata_q, mem_wdata_d;
    logic [ADDR_W-1:0]                mem_addr_q, mem_addr_d;
    logic                             mem_we_q, mem_we_d;
    logic                             done_q, done_d;
    logic                             err_q, err_d;

    logic [NUM_CORES-1:0] disp_req, disp_gnt, col_req, col_gnt;
    logic                 disp_vld, col_vld;
    logic [PW-1:0]        disp_idx, col_idx;
    logic [CNT_W-1:0]     col_tag;
    logic [NONCE_W-1:0]   col_h0;

    // res_ack_q masks a result level that is still high the cycle after its ack.
    assign disp_req = core_ready & ~busy_q;
    assign col_req  = res_valid & busy_q & ~res_ack_q;

    rr_arbiter #(.W(NUM_CORES), .PW(PW)) u_disp_arb (
        .req   (disp_req),
        .ptr   (disp_ptr_q),
        .gnt   (disp_gnt),
        .valid (disp_vld)
    );

    rr_arbiter #(.W(NUM_CORES), .PW(PW)) u_col_arb (
        .req   (col_req),
        .ptr   (col_ptr_q),
        .gnt   (col_gnt),
        .valid (col_vld)
    );

    always_comb begin
        disp_idx = '0;
        col_idx  = '0;
        col_tag  = '0;
        col_h0   = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (disp_gnt[i]) disp_idx = PW'(i);
            if (col_gnt[i]) begin
                col_idx = PW'(i);
                col_tag = tag_q[i];
                col_h0  = res_h0[i*NONCE_W +: NONCE_W];
            end
        end
    end

    function automatic logic [PW-1:0] ptr_after(input logic [PW-1:0] idx);
        return (int'(idx) == NUM_CORES - 1) ? '0 : idx + 1'b1;
    endfunction

    always_comb begin
        state_d      = state_q;
        out_base_d   = out_base_q;
        next_nonce_d = next_nonce_q;
        written_d    = written_q;
        busy_d       = busy_q;
        tag_d        = tag_q;
        disp_ptr_d   = disp_ptr_q;
        col_ptr_d    = col_ptr_q;
        core_start_d = '0;
        core_nonce_d = core_nonce_q;
        res_ack_d    = '0;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        done_d       = done_q;
        err_d        = err_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d      = RUN;
                    out_base_d   = output_addr;
                    next_nonce_d = '0;
                    written_d    = '0;
                    busy_d       = '0;
                    err_d        = 1'b0;
                    done_d       = 1'b0;
                end
            end
            RUN: begin
                if (disp_vld && (next_nonce_q < LAST)) begin
                    core_start_d       = disp_gnt;
                    core_nonce_d       = NONCE_W'(next_nonce_q);
                    busy_d             = busy_d | disp_gnt;
                    tag_d[disp_idx]    = next_nonce_q;
                    next_nonce_d       = next_nonce_q + 1'b1;
                    disp_ptr_d         = ptr_after(disp_idx);
                end
                // Dispatch only grants non-busy cores and collect only busy ones,
                // so the set and clear below never touch the same bit.
                if (col_vld) begin
                    res_ack_d   = col_gnt;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = out_base_q + col_tag;
                    mem_wdata_d = col_h0;
                    busy_d      = busy_d & ~col_gnt;
                    written_d   = written_q + 1'b1;
                    col_ptr_d   = ptr_after(col_idx);
                    if (written_d == LAST) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
                if ((res_valid & ~busy_q & ~res_ack_q) != '0) err_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            out_base_q   <= '0;
            next_nonce_q <= '0;
            written_q    <= '0;
            busy_q       <= '0;
            tag_q        <= '0;
            disp_ptr_q   <= '0;
            col_ptr_q    <= '0;
            core_start_q <= '0;
            core_nonce_q <= '0;
            res_ack_q    <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            out_base_q   <= out_base_d;
            next_nonce_q <= next_nonce_d;
            written_q    <= written_d;
            busy_q       <= busy_d;
            tag_q        <= tag_d;
            disp_ptr_q   <= disp_ptr_d;
            col_ptr_q    <= col_ptr_d;
            core_start_q <= core_start_d;
            core_nonce_q <= core_nonce_d;
            res_ack_q    <= res_ack_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign done           = done_q;
    assign core_start     = core_start_q;
    assign core_nonce     = core_nonce_q;
    assign res_ack        = res_ack_q;
    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_write_data = mem_wdata_q;
    assign err            = err_q;
endmodule
